// File: rtl/tmr_error_monitor_if.sv
// Readout and error-flag bundle between the TMR error monitor and its
// consumer (slow control / scrub fan-out). The monitor side is the master.
interface tmr_error_monitor_if #(
    parameter int N_CH  = 8,
    parameter int CNT_W = 16
);
    logic [N_CH-1:0]  tmrErr;
    logic             scrub;
    logic             errAny;
    logic             rdReq;
    logic             rdValid;
    logic             rdReady;
    logic [CNT_W-1:0] rdCount;
    logic [N_CH-1:0]  rdFlags;
    logic             rdOverflow;

    modport master (
        input  tmrErr, rdReq, rdReady,
        output scrub, errAny, rdValid, rdCount, rdFlags, rdOverflow
    );

    modport slave (
        output tmrErr, rdReq, rdReady,
        input  scrub, errAny, rdValid, rdCount, rdFlags, rdOverflow
    );
endinterface

// File: rtl/tmr_error_monitor.sv
// TMR error monitor: detects rising edges on voter mismatch flags, keeps a
// saturating event count plus sticky per-channel flags, stretches a scrub
// pulse after every event and hands out a clear-on-read snapshot through a
// valid/ready readout.
module tmr_error_monitor #(
    parameter int N_CH      = 8,
    parameter int CNT_W     = 16,
    parameter int SCRUB_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    tmr_error_monitor_if.master bus
);
    localparam int POP_W = $clog2(N_CH + 1);
    // The adder is one bit wider than the counter so clipping can be seen;
    // it is widened further only when the popcount itself would not fit.
    localparam int SUM_W = (CNT_W + 1 > POP_W) ? CNT_W + 1 : POP_W;
    localparam int SCR_W = $clog2(SCRUB_LEN + 1);
    localparam logic [SCR_W-1:0] SCRUB_LOAD = SCR_W'(SCRUB_LEN);
    localparam logic [SUM_W-1:0] CNT_MAX    = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_VALID = 1'b1
    } state_t;

    function automatic logic [POP_W-1:0] popcount(input logic [N_CH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_CH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_cnt(input logic [SUM_W-1:0] s);
        return (s > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : s[CNT_W-1:0];
    endfunction

    logic [N_CH-1:0]  r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [N_CH-1:0]  r_flags;
    logic             r_ovf;
    logic             r_err_any;
    logic [SCR_W-1:0] r_scrub_cnt;
    state_t           r_state;
    logic [CNT_W-1:0] r_rd_count;
    logic [N_CH-1:0]  r_rd_flags;
    logic             r_rd_ovf;

    logic [N_CH-1:0]  w_ev;
    logic [POP_W-1:0] w_pop;
    logic [SUM_W-1:0] w_sum;
    logic             w_clip;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [N_CH-1:0]  w_flags_nxt;
    logic             w_ovf_nxt;
    state_t           w_state_nxt;
    logic             w_snap;

    // Rising-edge events and the live values they produce this cycle
    assign w_ev        = bus.tmrErr & ~r_prev;
    assign w_pop       = popcount(w_ev);
    assign w_sum       = SUM_W'(r_cnt) + SUM_W'(w_pop);
    assign w_clip      = (w_sum > CNT_MAX);
    assign w_cnt_nxt   = sat_cnt(w_sum);
    assign w_ovf_nxt   = r_ovf | w_clip;
    assign w_flags_nxt = r_flags | w_ev;

    // Readout FSM next state; a snapshot is taken only on the IDLE request edge
    always_comb begin
        w_state_nxt = r_state;
        w_snap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.rdReq) begin
                    w_snap      = 1'b1;
                    w_state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (bus.rdReady) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Readout FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Previous tmrErr sample for edge detection; cleared so a line high at release counts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= bus.tmrErr;
        end
    end

    // Live counter/flags: restart from zero on a snapshot, the current events go to the snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_flags   <= '0;
            r_ovf     <= 1'b0;
            r_err_any <= 1'b0;
        end else if (w_snap) begin
            r_cnt     <= '0;
            r_flags   <= '0;
            r_ovf     <= 1'b0;
            r_err_any <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_flags   <= w_flags_nxt;
            r_ovf     <= w_ovf_nxt;
            r_err_any <= |w_flags_nxt;
        end
    end

    // Snapshot registers hold their value until the next request is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
            r_rd_flags <= '0;
            r_rd_ovf   <= 1'b0;
        end else if (w_snap) begin
            r_rd_count <= w_cnt_nxt;
            r_rd_flags <= w_flags_nxt;
            r_rd_ovf   <= w_ovf_nxt;
        end
    end

    // Scrub down-counter, reloaded by every event so bursts stretch the pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scrub_cnt <= '0;
        end else if (|w_ev) begin
            r_scrub_cnt <= SCRUB_LOAD;
        end else if (r_scrub_cnt != '0) begin
            r_scrub_cnt <= r_scrub_cnt - SCR_W'(1);
        end
    end

    assign bus.scrub      = (r_scrub_cnt != '0);
    assign bus.errAny     = r_err_any;
    assign bus.rdValid    = (r_state == S_VALID);
    assign bus.rdCount    = r_rd_count;
    assign bus.rdFlags    = r_rd_flags;
    assign bus.rdOverflow = r_rd_ovf;

endmodule

// File: tb/tb_tmr_error_monitor.sv
// Bench for tmr_error_monitor: a default build (CNT_W=16) and a narrow
// counter build (CNT_W=2) share clock and reset. Expected snapshots are
// queued when a read is requested and compared when the DUT presents them.
module tb_tmr_error_monitor;
    logic clk;
    logic rst;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         cnt;
        logic [7:0] flags;
        bit         ovf;
    } snap_t;

    snap_t sb_q[$];

    tmr_error_monitor_if #(.N_CH(8), .CNT_W(16)) ifa ();
    tmr_error_monitor_if #(.N_CH(8), .CNT_W(2))  ifb ();

    tmr_error_monitor #(.N_CH(8), .CNT_W(16), .SCRUB_LEN(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    tmr_error_monitor #(.N_CH(8), .CNT_W(2), .SCRUB_LEN(4)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit get_valid(input bit sel_b);
        return sel_b ? ifb.rdValid : ifa.rdValid;
    endfunction

    task automatic push_exp(input int ec, input logic [7:0] ef, input bit eo);
        snap_t s;
        s.cnt   = ec;
        s.flags = ef;
        s.ovf   = eo;
        sb_q.push_back(s);
    endtask

    task automatic compare_pop(input bit sel_b, input string tag);
        snap_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
        end else begin
            e.cnt   = -1;
            e.flags = 8'hxx;
            e.ovf   = 1'b1;
        end
        if (sel_b) begin
            chk({tag, "_count"}, 64'(ifb.rdCount),    64'(e.cnt));
            chk({tag, "_flags"}, 64'(ifb.rdFlags),    64'(e.flags));
            chk({tag, "_ovf"},   64'(ifb.rdOverflow), 64'(e.ovf));
        end else begin
            chk({tag, "_count"}, 64'(ifa.rdCount),    64'(e.cnt));
            chk({tag, "_flags"}, 64'(ifa.rdFlags),    64'(e.flags));
            chk({tag, "_ovf"},   64'(ifa.rdOverflow), 64'(e.ovf));
        end
    endtask

    // Full read transaction: request, bounded wait for valid, compare, accept.
    task automatic do_read(input bit sel_b, input int ec, input logic [7:0] ef,
                           input bit eo, input string tag);
        int w;
        if (sel_b) ifb.rdReq = 1'b1; else ifa.rdReq = 1'b1;
        push_exp(ec, ef, eo);
        tick();
        if (sel_b) ifb.rdReq = 1'b0; else ifa.rdReq = 1'b0;
        w = 0;
        while (!get_valid(sel_b) && w < 8) begin
            tick();
            w++;
        end
        chk({tag, "_latency"}, 64'(w), 64'(0));
        compare_pop(sel_b, tag);
        if (sel_b) ifb.rdReady = 1'b1; else ifa.rdReady = 1'b1;
        tick();
        if (sel_b) ifb.rdReady = 1'b0; else ifa.rdReady = 1'b0;
        chk({tag, "_valid_drop"}, 64'(get_valid(sel_b)), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst         = 1'b1;
        ifa.tmrErr  = '0;
        ifa.rdReq   = 1'b0;
        ifa.rdReady = 1'b0;
        ifb.tmrErr  = '0;
        ifb.rdReq   = 1'b0;
        ifb.rdReady = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scrub",   64'(ifa.scrub),   64'(0));
        chk("rst_errany",  64'(ifa.errAny),  64'(0));
        chk("rst_rdvalid", 64'(ifa.rdValid), 64'(0));
        chk("rst_rdcount", 64'(ifa.rdCount), 64'(0));
        rst = 1'b0;

        // Idle after reset
        repeat (20) tick();
        chk("idle_scrub",   64'(ifa.scrub),   64'(0));
        chk("idle_errany",  64'(ifa.errAny),  64'(0));
        chk("idle_rdvalid", 64'(ifa.rdValid), 64'(0));

        // Single channel held high for 10 cycles counts once
        ifa.tmrErr = 8'h04;
        n = 0;
        tick();
        chk("t2_errany", 64'(ifa.errAny), 64'(1));
        if (ifa.scrub) n++;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ifa.scrub) n++;
        end
        chk("t2_scrub_len", 64'(n), 64'(4));
        ifa.tmrErr = 8'h00;
        do_read(1'b0, 1, 8'h04, 1'b0, "t2");
        chk("t2_errany_clr", 64'(ifa.errAny), 64'(0));

        // Three channels at once, snapshot taken, then a second event extends scrub
        ifa.tmrErr = 8'hA1;
        n = 0;
        tick();
        if (ifa.scrub) n++;
        ifa.rdReq = 1'b1;
        push_exp(3, 8'hA1, 1'b0);
        tick();
        if (ifa.scrub) n++;
        ifa.rdReq = 1'b0;
        chk("t3_valid", 64'(ifa.rdValid), 64'(1));
        ifa.tmrErr = 8'hA9;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ifa.scrub) n++;
            if (i == 3) chk("t3_scrub_last", 64'(ifa.scrub), 64'(1));
            if (i == 4) chk("t3_scrub_end",  64'(ifa.scrub), 64'(0));
        end
        chk("t3_scrub_total", 64'(n), 64'(6));
        compare_pop(1'b0, "t3a");
        ifa.rdReady = 1'b1;
        tick();
        ifa.rdReady = 1'b0;
        chk("t3_valid_drop", 64'(ifa.rdValid), 64'(0));
        ifa.tmrErr = 8'h00;
        do_read(1'b0, 1, 8'h08, 1'b0, "t3b");

        // Request coincident with an event; consumer stalls while more events arrive
        ifa.tmrErr = 8'h02;
        ifa.rdReq  = 1'b1;
        push_exp(1, 8'h02, 1'b0);
        tick();
        ifa.rdReq = 1'b0;
        chk("t5_valid", 64'(ifa.rdValid), 64'(1));
        compare_pop(1'b0, "t5a");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) ifa.tmrErr = 8'h12;
            if (i == 2) ifa.rdReq  = 1'b1;
            if (i == 3) begin
                ifa.tmrErr = 8'h52;
                ifa.rdReq  = 1'b0;
            end
            tick();
            chk("t5_hold",
                64'({ifa.rdValid, ifa.rdOverflow, ifa.rdFlags, ifa.rdCount}),
                64'({1'b1, 1'b0, 8'h02, 16'd1}));
        end
        chk("t5_errany", 64'(ifa.errAny), 64'(1));
        ifa.rdReady = 1'b1;
        tick();
        ifa.rdReady = 1'b0;
        chk("t5_valid_drop", 64'(ifa.rdValid), 64'(0));
        ifa.tmrErr = 8'h00;
        do_read(1'b0, 2, 8'h50, 1'b0, "t5b");

        // Reset while a snapshot is pending and scrub is active
        ifa.tmrErr = 8'h01;
        ifa.rdReq  = 1'b1;
        tick();
        ifa.rdReq = 1'b0;
        chk("t6_pre_valid", 64'(ifa.rdValid), 64'(1));
        chk("t6_pre_scrub", 64'(ifa.scrub),   64'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_outs",
            64'({ifa.rdValid, ifa.scrub, ifa.errAny, ifa.rdOverflow, ifa.rdFlags, ifa.rdCount}),
            64'(0));
        ifa.tmrErr = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        do_read(1'b0, 0, 8'h00, 1'b0, "t6");

        // A line already high when reset releases counts on the first edge
        rst        = 1'b1;
        ifa.tmrErr = 8'h10;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rel_errany", 64'(ifa.errAny), 64'(1));
        chk("t6_rel_scrub",  64'(ifa.scrub),  64'(1));
        ifa.tmrErr = 8'h00;
        do_read(1'b0, 1, 8'h10, 1'b0, "t6b");

        // Narrow counter saturates and sets overflow; both clear on read
        for (int i = 0; i < 5; i++) begin
            ifb.tmrErr = 8'h01;
            tick();
            ifb.tmrErr = 8'h00;
            tick();
        end
        do_read(1'b1, 3, 8'h01, 1'b1, "t4a");
        do_read(1'b1, 0, 8'h00, 1'b0, "t4b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
